// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// FSM state encoding, requester ids and the saturating wait-counter helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Wide enough for the largest legal MAX_WAIT (15).
  localparam int WAIT_W = 4;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v,
                                                input logic [WAIT_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + WAIT_W'(1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_perf.sv
// Wrap-around grant and conflict counters for CPI analysis of the unified
// memory arbiter; each counter advances by one when its enable is high.
module arb_perf_counters #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc_if,
  input  logic             i_inc_d,
  input  logic             i_inc_conflict,
  output logic [WIDTH-1:0] o_cnt_if,
  output logic [WIDTH-1:0] o_cnt_d,
  output logic [WIDTH-1:0] o_cnt_conflict
);

  logic [WIDTH-1:0] r_cnt_if;
  logic [WIDTH-1:0] r_cnt_d;
  logic [WIDTH-1:0] r_cnt_conflict;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt_if       <= '0;
      r_cnt_d        <= '0;
      r_cnt_conflict <= '0;
    end else begin
      if (i_inc_if)       r_cnt_if       <= r_cnt_if + WIDTH'(1);
      if (i_inc_d)        r_cnt_d        <= r_cnt_d + WIDTH'(1);
      if (i_inc_conflict) r_cnt_conflict <= r_cnt_conflict + WIDTH'(1);
    end
  end

  assign o_cnt_if       = r_cnt_if;
  assign o_cnt_d        = r_cnt_d;
  assign o_cnt_conflict = r_cnt_conflict;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous-read memory between instruction fetch
// and data access: data has fixed priority, fetch is forced after MAX_WAIT losses.
//
// Handshake: a requester raises *_req with its address/data and holds them until
// the matching *_ready pulse; the access is issued combinationally in IDLE and
// *_ready (with *_rdata) appears exactly one cycle later. Dropping a request
// before it is granted is legal and simply abandons it.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDRBITS = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDRBITS-1:0] if_addr,
  output logic                if_ready,
  output logic [WIDTH-1:0]    if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDRBITS-1:0] d_addr,
  input  logic [WIDTH-1:0]    d_wdata,
  output logic                d_ready,
  output logic [WIDTH-1:0]    d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic [WIDTH-1:0]    cnt_if,
  output logic [WIDTH-1:0]    cnt_d,
  output logic [WIDTH-1:0]    cnt_conflict,
  output logic [1:0]          o_dbg_state,
  output logic [WAIT_W-1:0]   o_dbg_wait_cnt
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_L = WAIT_W'(MAX_WAIT);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_next_wait;
  logic              w_grant_if;
  logic              w_grant_d;
  logic              w_conflict;
  logic              w_if_ready;
  logic              w_d_ready;
  logic              r_d_is_load;
  logic [WIDTH-1:0]  r_if_rdata;
  logic [WIDTH-1:0]  r_d_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait;
    end
  end

  // Next-state and grant decision
  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait_cnt;
    w_grant_if   = 1'b0;
    w_grant_d    = 1'b0;
    w_conflict   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!if_req) w_next_wait = '0;
        if (if_req && d_req) begin
          w_conflict = 1'b1;
          if (r_wait_cnt == MAX_WAIT_L) begin
            w_grant_if  = 1'b1;
            w_next_wait = '0;
          end else begin
            w_grant_d   = 1'b1;
            w_next_wait = sat_inc(r_wait_cnt, MAX_WAIT_L);
          end
        end else if (d_req) begin
          w_grant_d = 1'b1;
        end else if (if_req) begin
          w_grant_if  = 1'b1;
          w_next_wait = '0;
        end
        if (w_grant_if)     w_next_state = RESP_I;
        else if (w_grant_d) w_next_state = RESP_D;
      end
      RESP_I:  w_next_state = IDLE;
      RESP_D:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs. Gating with rst keeps a reset cycle from issuing an access or
  // answering the response that the reset is about to discard.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    w_if_ready = 1'b0;
    w_d_ready  = 1'b0;
    if (rst) begin
      if (w_grant_d) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else if (w_grant_if) begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      w_if_ready = (r_state == RESP_I);
      w_d_ready  = (r_state == RESP_D);
    end
  end

  assign if_ready = w_if_ready;
  assign d_ready  = w_d_ready;
  assign if_rdata = w_if_ready ? mem_rdata : r_if_rdata;
  assign d_rdata  = (w_d_ready && r_d_is_load) ? mem_rdata : r_d_rdata;

  // Read-data holding registers; stores leave the data-side value untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_d_is_load <= 1'b0;
    end else begin
      if (w_if_ready)                r_if_rdata  <= mem_rdata;
      if (w_d_ready && r_d_is_load)  r_d_rdata   <= mem_rdata;
      if (w_grant_d)                 r_d_is_load <= ~d_we;
    end
  end

  arb_perf_counters #(.WIDTH(WIDTH)) u_perf (
    .clk            (clk),
    .rst            (rst),
    .i_inc_if       (w_grant_if),
    .i_inc_d        (w_grant_d),
    .i_inc_conflict (w_conflict),
    .o_cnt_if       (cnt_if),
    .o_cnt_d        (cnt_d),
    .o_cnt_conflict (cnt_conflict)
  );

  assign o_dbg_state    = r_state;
  assign o_dbg_wait_cnt = r_wait_cnt;

endmodule
